// File: rtl/clip_player_ctrl.sv
// clip_player_ctrl
//   Plays a mono sample clip from an external synchronous ROM into an I2S
//   transmitter's sample holding register. Each sample is fetched, converted
//   from offset binary to two's complement, attenuated by an arithmetic right
//   shift, and then held until the transmitter consumes it.
//
//   State table
//     IDLE  | no playback; waiting for start
//     FETCH | rom_addr presents the current sample address
//     WAIT  | rom_data is valid; sample is converted and captured
//     HOLD  | sample_valid=1, waiting for sample_ready to consume it
//
// Ports
//   mclk, resetn       clock and synchronous active-low reset
//   start, stop        one-cycle playback control pulses (stop wins)
//   loop_en, attn      wrap-around enable and attenuation shift amount
//   rom_addr/rom_data  sample ROM interface (data valid 1 cycle after addr)
//   sample_l/_r        identical signed output samples
//   sample_valid       sample pending; consumed by sample_ready
//   busy, done         activity flag and end-of-clip pulse
//   underrun_cnt       saturating count of frames with no sample available
module clip_player_ctrl #(
    parameter int CLIP_LEN = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 16
) (
    input  logic              mclk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [2:0]        attn,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       underrun_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLIP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   smp_q, smp_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic [15:0]         ucnt_q, ucnt_d;

    // Offset binary to two's complement is just an MSB flip.
    logic signed [DATA_W-1:0] conv_s;
    logic [DATA_W-1:0]        shifted;

    assign conv_s  = {~rom_data[DATA_W-1], rom_data[DATA_W-2:0]};
    assign shifted = conv_s >>> attn;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        smp_d   = smp_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        ucnt_d  = ucnt_q;

        if (sample_ready && (state_q != S_IDLE) && !valid_q && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                smp_d   = shifted;
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (sample_ready) begin
                    valid_d = 1'b0;
                    if (addr_q != LAST_ADDR) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort and restart override whatever the active state decided,
        // including a handshake or capture in the same cycle.
        if (state_q != S_IDLE) begin
            if (stop) begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                smp_d   = '0;
                done_d  = 1'b0;
            end else if (start) begin
                state_d = S_FETCH;
                addr_d  = '0;
                valid_d = 1'b0;
                smp_d   = smp_q;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            smp_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ucnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            smp_q   <= smp_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign rom_addr     = addr_q;
    assign sample_l     = smp_q;
    assign sample_r     = smp_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_clip_player_ctrl.sv
// Testbench for clip_player_ctrl: synchronous ROM model, behavioural
// reference model of the player, directed scenarios and a randomized run.
module tb_clip_player_ctrl;

    logic        mclk;
    logic        resetn;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [2:0]  attn;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic [15:0] underrun_cnt;

    clip_player_ctrl #(.CLIP_LEN(32), .ADDR_W(5), .DATA_W(16)) dut (
        .mclk         (mclk),
        .resetn       (resetn),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .attn         (attn),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    logic [15:0] rom [32];
    always @(posedge mclk) rom_data <= rom[rom_addr];

    int checks = 0;
    int failures = 0;

    // Reference model: player is either idle or working on clip index m_idx.
    // m_age counts cycles since the address was issued; the sample lands two
    // edges after issue and then waits for a consumer.
    logic        m_active = 1'b0;
    logic        m_valid  = 1'b0;
    logic [15:0] m_smp    = 16'h0;
    logic        m_done   = 1'b0;
    int          m_ucnt   = 0;
    int          m_idx    = 0;
    int          m_age    = 0;

    logic [15:0] hs[$];
    int          done_cnt = 0;
    logic        busy_at_done = 1'b1;

    function automatic logic [15:0] expect_sample(input logic [15:0] word, input logic [2:0] sh);
        int v;
        v = int'(word) - 32768;
        v = v >>> sh;
        return v[15:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!resetn) begin
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_smp    = 16'h0;
            m_ucnt   = 0;
            m_idx    = 0;
            m_age    = 0;
        end else begin
            if (sample_ready && m_active && !m_valid && m_ucnt < 65535) m_ucnt++;
            if (m_active && stop) begin
                m_active = 1'b0;
                m_valid  = 1'b0;
                m_smp    = 16'h0;
            end else if (start && !stop) begin
                m_active = 1'b1;
                m_valid  = 1'b0;
                m_idx    = 0;
                m_age    = 0;
            end else if (m_active) begin
                if (!m_valid) begin
                    if (m_age == 1) begin
                        m_smp   = expect_sample(rom[m_idx], attn);
                        m_valid = 1'b1;
                    end else begin
                        m_age++;
                    end
                end else if (sample_ready) begin
                    m_valid = 1'b0;
                    m_age   = 0;
                    if (m_idx < 31) m_idx++;
                    else if (loop_en) m_idx = 0;
                    else begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(m_active));
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("sample_l", 32'(sample_l), 32'(m_smp));
        chk("sample_r", 32'(sample_r), 32'(m_smp));
        chk("done", 32'(done), 32'(m_done));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
        if (m_active && !m_valid && m_age == 0) chk("rom_addr", 32'(rom_addr), 32'(m_idx));
        if (done) begin
            done_cnt++;
            busy_at_done = busy;
        end
    endtask

    task automatic tick();
        if (resetn && sample_ready && sample_valid && !stop && !start) hs.push_back(sample_l);
        @(posedge mclk);
        model_step();
        @(negedge mclk);
        compare();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!sample_valid && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(sample_valid), 32'd1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 32; i++) rom[i] = 16'h8000 + 16'(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        resetn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        attn = 3'd0;
        sample_ready = 1'b0;
        load_ramp();

        // reset state
        tick();
        tick();
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample", 32'(sample_l), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_after_reset", 32'(busy), 32'd0);

        // full non-looping clip, consumer every 8 cycles
        hs.delete();
        done_cnt = 0;
        pulse_start();
        lat = 1;
        while (!sample_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("start_to_valid", 32'(lat), 32'd3);
        for (int c = 0; c < 400 && done_cnt == 0; c++) begin
            sample_ready = (c % 8 == 0);
            tick();
        end
        sample_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("clip_count", 32'(hs.size()), 32'd32);
        for (int i = 0; i < hs.size() && i < 32; i++) chk("clip_value", 32'(hs[i]), 32'(i));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_at_done", 32'(busy_at_done), 32'd0);

        // looping clip, loop_en dropped after 40 handshakes
        hs.delete();
        done_cnt = 0;
        loop_en = 1'b1;
        pulse_start();
        for (int c = 0; c < 800 && done_cnt == 0; c++) begin
            sample_ready = (c % 8 == 7);
            tick();
            if (hs.size() == 40 && loop_en) begin
                chk("loop_sample33", 32'(hs[32]), 32'd0);
                chk("loop_no_done", 32'(done_cnt), 32'd0);
                loop_en = 1'b0;
            end
        end
        sample_ready = 1'b0;
        chk("loop_count", 32'(hs.size()), 32'd64);
        if (hs.size() == 64) chk("loop_last", 32'(hs[63]), 32'd31);
        chk("loop_done", 32'(done_cnt), 32'd1);
        tick();

        // attenuation extremes
        rom[0] = 16'h0000;
        rom[1] = 16'hFFFF;
        attn = 3'd3;
        pulse_start();
        wait_valid("attn3_valid");
        chk("attn3_sample", 32'(sample_l), 32'h0000F000);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        attn = 3'd7;
        wait_valid("attn7_valid");
        chk("attn7_sample", 32'(sample_r), 32'h000000FF);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        attn = 3'd0;
        load_ramp();

        // stop in HOLD with a coincident handshake
        done_cnt = 0;
        pulse_start();
        wait_valid("hold_valid");
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        wait_valid("hold_valid2");
        sample_ready = 1'b1;
        stop = 1'b1;
        tick();
        sample_ready = 1'b0;
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_valid", 32'(sample_valid), 32'd0);
        chk("stop_sample", 32'(sample_l), 32'd0);
        tick();
        chk("stop_no_done", 32'(done_cnt), 32'd0);

        // start+stop in IDLE and in FETCH
        start = 1'b1;
        stop = 1'b1;
        tick();
        chk("startstop_idle", 32'(busy), 32'd0);
        stop = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_fetch", 32'(busy), 32'd0);

        // restart during WAIT after the address has advanced
        pulse_start();
        wait_valid("rs_valid");
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("rs_addr1", 32'(rom_addr), 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_addr0", 32'(rom_addr), 32'd0);
        chk("rs_valid0", 32'(sample_valid), 32'd0);
        wait_valid("rs_valid_again");
        chk("rs_sample", 32'(sample_l), 32'd0);

        // reset during playback together with start
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        wait_valid("mr_valid");
        resetn = 1'b0;
        start = 1'b1;
        tick();
        resetn = 1'b1;
        start = 1'b0;
        chk("mr_rom_addr", 32'(rom_addr), 32'd0);
        chk("mr_sample", 32'(sample_l), 32'd0);
        chk("mr_valid", 32'(sample_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_ucnt", 32'(underrun_cnt), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_idle", 32'(busy), 32'd0);

        // randomized run against the model
        for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
        for (int c = 0; c < 4000; c++) begin
            resetn = ($urandom_range(499) != 0);
            start = ($urandom_range(39) == 0);
            stop = ($urandom_range(79) == 0);
            sample_ready = ($urandom_range(3) == 0);
            if ($urandom_range(99) == 0) loop_en = ~loop_en;
            attn = 3'($urandom_range(7));
            tick();
        end
        resetn = 1'b1;
        start = 1'b0;
        stop = 1'b0;

        // consumer asserting ready every cycle: two underruns per sample
        load_ramp();
        loop_en = 1'b0;
        attn = 3'd0;
        resetn = 1'b0;
        sample_ready = 1'b0;
        tick();
        resetn = 1'b1;
        done_cnt = 0;
        sample_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 200 && done_cnt == 0; c++) tick();
        chk("ur_done", 32'(done_cnt), 32'd1);
        chk("ur_per_sample", 32'(underrun_cnt), 32'd64);
        start = 1'b1;
        tick();
        chk("ur_start_keeps", 32'(underrun_cnt), 32'd64);
        // repeated restarts keep the player out of HOLD so every cycle counts
        for (int c = 0; c < 65600; c++) tick();
        chk("ur_saturate", 32'(underrun_cnt), 32'h0000FFFF);
        start = 1'b0;
        sample_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("ur_hold_sat", 32'(underrun_cnt), 32'h0000FFFF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
